// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: starts arithmetic ops, applies
// HI/LO writes, stalls HI/LO reads and watches for lost or hung operations.
module md_issue_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [3:0] ex_md_op,
  input  logic       irq,
  input  logic       eret,
  input  logic       md_busy,
  output logic       md_start,
  output logic [3:0] md_op_out,
  output logic       stall,
  output logic       md_done,
  output logic       md_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUED,
    ST_WAIT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       issued_idle, issued_idle_next;
  logic       err_set;

  logic is_arith, is_write, is_read, is_md, is_illegal;
  logic kill, go;

  always_comb begin
    is_arith   = (ex_md_op >= 4'd1) && (ex_md_op <= 4'd8);
    is_write   = (ex_md_op == 4'd9) || (ex_md_op == 4'd10);
    is_read    = (ex_md_op == 4'd11) || (ex_md_op == 4'd12);
    is_md      = is_arith || is_write || is_read;
    is_illegal = (ex_md_op >= 4'd13);
  end

  // Outputs are forced low while reset is asserted so the pipeline never sees
  // a start or stall from a controller whose state is about to be discarded.
  always_comb begin
    kill      = irq | eret;
    go        = ~reset & ex_valid & ~kill & (state == ST_IDLE) & ~md_busy;
    md_start  = go & is_arith;
    md_op_out = (go & (is_arith | is_write)) ? ex_md_op : 4'd0;
    stall     = ~reset & ex_valid & ~kill & is_md & ((state != ST_IDLE) | md_busy);
    md_done   = ~reset & (state == ST_WAIT) & ~md_busy;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_next       = state;
    wait_cnt_next    = wait_cnt;
    issued_idle_next = issued_idle;
    err_set          = ex_valid & is_illegal;

    unique case (state)
      ST_IDLE: begin
        if (md_start) begin
          state_next       = ST_ISSUED;
          wait_cnt_next    = 8'd0;
          issued_idle_next = 1'b0;
        end
      end
      ST_ISSUED: begin
        // A unit that never raises busy has dropped the op; give it two cycles.
        if (md_busy) begin
          state_next = ST_WAIT;
        end else if (issued_idle) begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end else begin
          issued_idle_next = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!md_busy) begin
          state_next = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 8'd0;
      issued_idle <= 1'b0;
      md_err      <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      issued_idle <= issued_idle_next;
      if (err_set) md_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: one instance at the default TIMEOUT and one
// at TIMEOUT=4 share the stimulus; expected values are hand-derived per cycle.
module tb_md_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid;
  logic [3:0] ex_md_op;
  logic       irq, eret, md_busy;

  logic       md_start, stall, md_done, md_err;
  logic [3:0] md_op_out;
  logic       md_start4, stall4, md_done4, md_err4;
  logic [3:0] md_op_out4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
    .irq(irq), .eret(eret), .md_busy(md_busy), .md_start(md_start),
    .md_op_out(md_op_out), .stall(stall), .md_done(md_done), .md_err(md_err)
  );

  md_issue_ctrl #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
    .irq(irq), .eret(eret), .md_busy(md_busy), .md_start(md_start4),
    .md_op_out(md_op_out4), .stall(stall4), .md_done(md_done4), .md_err(md_err4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic v, input logic [3:0] op, input logic i,
                      input logic e, input logic b);
    ex_valid = v;
    ex_md_op = op;
    irq      = i;
    eret     = e;
    md_busy  = b;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    step(1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Reset cycle with a valid mult and an illegal op pending: all quiet.
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("rst_start", md_start, 0);
    check("rst_op_out", md_op_out, 0);
    check("rst_stall", stall, 0);
    check("rst_done", md_done, 0);
    check("rst_err", md_err, 0);
    next_cycle();
    reset = 1'b0;

    // mult: start at cycle 0, busy cycles 1-5, done at cycle 6.
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("mult_start", md_start, 1);
    check("mult_op_out", md_op_out, 1);
    check("mult_stall", stall, 0);
    next_cycle();
    for (int c = 1; c <= 5; c++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("mult_busy_done", md_done, 0);
      next_cycle();
    end
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("mult_done", md_done, 1);
    check("mult_no_err", md_err, 0);
    next_cycle();
    step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    check("mult_idle_stall", stall, 0);
    check("mult_idle_done", md_done, 0);
    check("read_op_out", md_op_out, 0);
    next_cycle();

    // div then mflo, busy 10 cycles: mflo stalls 11 cycles.
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    check("div_start", md_start, 1);
    check("div_op_out", md_op_out, 3);
    next_cycle();
    for (int c = 1; c <= 10; c++) begin
      step(1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
      check("mflo_stall_busy", stall, 1);
      check("mflo_no_start", md_start, 0);
      next_cycle();
    end
    step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    check("mflo_stall_last", stall, 1);
    check("div_done", md_done, 1);
    next_cycle();
    step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    check("mflo_release", stall, 0);
    check("div_done_once", md_done, 0);
    next_cycle();

    // madd killed by irq, mult killed by eret, then mthi applies in IDLE.
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    check("madd_irq_start", md_start, 0);
    check("madd_irq_op_out", md_op_out, 0);
    check("madd_irq_stall", stall, 0);
    next_cycle();
    step(1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    check("mult_eret_start", md_start, 0);
    next_cycle();
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    check("mthi_idle_op_out", md_op_out, 9);
    check("mthi_idle_start", md_start, 0);
    check("mthi_idle_stall", stall, 0);
    next_cycle();

    // mthi while a mult is in WAIT stalls; a kill drops the stall but not the op.
    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    check("maddu_start", md_start, 1);
    check("maddu_op_out", md_op_out, 7);
    next_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
    check("mthi_wait_stall", stall, 1);
    check("mthi_wait_op_out", md_op_out, 0);
    check("mthi_wait_start", md_start, 0);
    next_cycle();
    step(1'b1, 4'd9, 1'b1, 1'b0, 1'b1);
    check("mthi_irq_stall", stall, 0);
    check("wait_irq_done", md_done, 0);
    next_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("after_irq_done", md_done, 1);
    next_cycle();

    // Unit never raises busy: two ISSUED cycles, then IDLE with md_err.
    step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    check("multu_start", md_start, 1);
    next_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("issued1_err", md_err, 0);
    check("issued1_done", md_done, 0);
    next_cycle();
    step(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
    check("issued2_stall", stall, 1);
    check("issued2_err", md_err, 0);
    next_cycle();
    step(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
    check("lost_err", md_err, 1);
    check("lost_idle_stall", stall, 0);
    check("lost_no_done", md_done, 0);
    next_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("err_sticky", md_err, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("err_cleared", md_err, 0);
    check("err4_cleared", md_err4, 0);

    // TIMEOUT=4 instance: busy stuck high, aborts after 4 WAIT cycles.
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    check("to_start4", md_start4, 1);
    next_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("to_wait_err4", md_err4, 0);
      check("to_wait_done4", md_done4, 0);
      next_cycle();
    end
    step(1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
    check("to_err4", md_err4, 1);
    check("to_done4", md_done4, 0);
    check("to_stall_busy4", stall4, 1);
    check("to_no_start4", md_start4, 0);
    check("to_default_err", md_err, 0);
    next_cycle();
    step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    check("to_stall_free4", stall4, 0);
    check("to_never_done4", md_done4, 0);
    check("default_done", md_done, 1);
    next_cycle();

    // Reset mid-WAIT: no md_done, next op issues right away.
    step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    check("msub_start", md_start, 1);
    next_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    reset = 1'b1;
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("rst_wait_done", md_done, 0);
    check("rst_wait_start", md_start, 0);
    next_cycle();
    reset = 1'b0;
    step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    check("post_rst_start", md_start, 1);
    check("post_rst_op_out", md_op_out, 8);
    check("post_rst_done", md_done, 0);
    next_cycle();
    reset = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    reset = 1'b0;

    // Illegal op: no start, no stall, md_err set on the edge.
    step(1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
    check("ill_start", md_start, 0);
    check("ill_stall", stall, 0);
    check("ill_op_out", md_op_out, 0);
    check("ill_err_pre", md_err, 0);
    next_cycle();
    step(1'b0, 4'd14, 1'b0, 1'b0, 1'b0);
    check("ill_err", md_err, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("ill_err_cleared", md_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, 15, max cycles in WAIT before abort (range 2..255).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ex_valid  input  1  EX-stage instruction valid.
REQ-005 SHALL have ex_md_op  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 msub, 7 maddu, 8 msubu, 9 mthi, 10 mtlo, 11 mfhi, 12 mflo, 13-15 illegal.
REQ-006 SHALL have irq  input  1  interrupt taken this cycle.
REQ-007 SHALL have eret  input  1  eret in EX this cycle.
REQ-008 SHALL have md_busy  input  1  Busy from multiply/divide unit.
REQ-009 SHALL have md_start  output  1  Start to multiply/divide unit.
REQ-010 SHALL have md_op_out  output  4  op code to multiply/divide unit.
REQ-011 SHALL have stall  output  1  freeze IF/ID/EX this cycle.
REQ-012 SHALL have md_done  output  1  one-cycle pulse when an issued op completes.
REQ-013 SHALL have md_err  output  1  sticky timeout/illegal-op flag.

Function
REQ-014 Classes: ARITH = codes 1-8; WRITE = 9,10; READ = 11,12; MD = ARITH|WRITE|READ; 13-15 treated as none, and set md_err when ex_valid.
REQ-015 State machine states IDLE, ISSUED, WAIT; state and outputs change only on clk rising edge.
REQ-016 kill = irq | eret; go = ex_valid & ~kill & state==IDLE & ~md_busy.
REQ-017 md_start SHALL be combinational = go & ARITH; md_op_out = ex_md_op when go & (ARITH|WRITE), else 0.
REQ-018 stall SHALL be combinational = ex_valid & ~kill & MD & (state!=IDLE | md_busy).
REQ-019 md_start SHALL never assert while state!=IDLE or md_busy=1 (unit overwrites on Start).
REQ-020 IDLE -> ISSUED when md_start=1; otherwise stay.
REQ-021 ISSUED -> WAIT when md_busy=1; ISSUED with md_busy=0 for 2 consecutive cycles -> IDLE, md_err set.
REQ-022 WAIT: wait counter (8 bit) increments each cycle; WAIT -> IDLE with md_done=1 for one cycle when md_busy samples 0.
REQ-023 WAIT counter reaching TIMEOUT with md_busy still 1 -> IDLE, md_err set, md_done=0; stall then follows md_busy per REQ-018.
REQ-024 Wait counter clears on every entry to ISSUED.
REQ-025 WRITE ops in IDLE with md_busy=0 complete in the same cycle (no state change, no stall).
REQ-026 READ ops stall until state==IDLE and md_busy=0; no md_start or md_op_out drive.
REQ-027 kill in the same cycle as an MD op: md_start=0, md_op_out=0, stall=0, state unchanged.
REQ-028 kill while in ISSUED/WAIT: does not cancel the in-flight op; state machine proceeds normally.
REQ-029 md_done and a new md_start SHALL never assert in the same cycle (md_done only in WAIT, go needs IDLE).
REQ-030 md_err clears only on reset.

Reset
REQ-031 reset=1 at a clk edge: state=IDLE, wait counter=0, md_err=0, md_done=0; reset overrides all other inputs that cycle.
REQ-032 During reset cycle combinational outputs md_start, md_op_out, stall SHALL be 0.
REQ-033 reset mid-WAIT: returns to IDLE without md_done; subsequent ops issue as soon as md_busy=0.

Verification
REQ-034 mult issued in IDLE, md_busy high cycles 1-5 after start -> md_start=1, md_op_out=1 at cycle 0; md_done=1 at cycle 6; state IDLE after.
REQ-035 div then mflo back-to-back, busy 10 cycles -> mflo stall=1 for 11 cycles, released cycle md_busy=0 and IDLE.
REQ-036 madd with irq=1 same cycle -> md_start=0, md_op_out=0, stall=0, state stays IDLE.
REQ-037 mthi in IDLE, md_busy=0 -> md_op_out=9, md_start=0, stall=0; mthi during WAIT -> stall=1, md_op_out=0.
REQ-038 TIMEOUT=4, md_busy held 1 indefinitely after start -> IDLE after 4 WAIT cycles, md_err=1, md_done never asserts.
REQ-039 ex_md_op=14 with ex_valid=1 -> md_err=1, no start, no stall; reset -> md_err=0.
